rob: RTL and testbench

Reorder buffer: the producer end of the commit broadcast that the reservation station consumes (`commit_en` / `commit_Number` / `commit_val`).
- Allocates one circular entry per issued instruction and hands its tag to issue as `ROB_Number`.
- Collects ALU results by tag and retires entries strictly in program order, one per cycle.
- Broadcasts each retired register value to the RS and the register file.
- On a mispredicted branch at the head, raises `clear` and provides the redirect PC.

---
 rtl/rob_if.sv | 37 +++
 rtl/rob.sv | 137 +++++++++++++
 tb/tb_rob.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// Issue / ALU / commit signal bundle between the reorder buffer and its neighbours.
// The master modport is the ROB side; slave is the surrounding pipeline.
interface rob_if #(
    parameter int TAG_W = 5
);
    logic             alloc_en;
    logic [4:0]       alloc_rd;
    logic             alloc_is_branch;
    logic [TAG_W-1:0] ROB_Number;
    logic             ROB_is_full;
    logic             alu_en;
    logic [TAG_W-1:0] alu_rob_number;
    logic [31:0]      alu_val;
    logic             alu_mispredict;
    logic             commit_en;
    logic [TAG_W-1:0] commit_Number;
    logic [31:0]      commit_val;
    logic [4:0]       commit_rd;
    logic             clear;
    logic [31:0]      redirect_pc;

    modport master (
        input  alloc_en, alloc_rd, alloc_is_branch,
        input  alu_en, alu_rob_number, alu_val, alu_mispredict,
        output ROB_Number, ROB_is_full,
        output commit_en, commit_Number, commit_val, commit_rd,
        output clear, redirect_pc
    );

    modport slave (
        output alloc_en, alloc_rd, alloc_is_branch,
        output alu_en, alu_rob_number, alu_val, alu_mispredict,
        input  ROB_Number, ROB_is_full,
        input  commit_en, commit_Number, commit_val, commit_rd,
        input  clear, redirect_pc
    );
endinterface

// File: rtl/rob.sv
// Circular reorder buffer: allocates tags in program order, collects ALU results,
// retires one entry per cycle and flushes everything on a mispredicted head branch.
module rob #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 5
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rdy_in,
    rob_if.master bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(DEPTH - 2);
    localparam logic [TAG_W-1:0] PTR_MASK = TAG_W'(DEPTH - 1);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

    logic             valid_r      [DEPTH];
    logic             ready_r      [DEPTH];
    logic             is_branch_r  [DEPTH];
    logic             mispredict_r [DEPTH];
    logic [4:0]       rd_r         [DEPTH];
    logic [31:0]      val_r        [DEPTH];

    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    logic             commit_en_r;
    logic [TAG_W-1:0] commit_number_r;
    logic [31:0]      commit_val_r;
    logic [4:0]       commit_rd_r;
    logic             clear_r;
    logic [31:0]      redirect_pc_r;

    logic [IDX_W-1:0] head_idx_s;
    logic [IDX_W-1:0] tail_idx_s;
    logic [IDX_W-1:0] alu_idx_s;
    logic             alu_tag_ok_s;
    logic             retire_s;
    logic             flush_s;
    logic             commit_s;
    logic             alloc_ok_s;
    logic             alu_ok_s;

    function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
        return (p + TAG_ONE) & PTR_MASK;
    endfunction

    assign head_idx_s   = head_r[IDX_W-1:0];
    assign tail_idx_s   = tail_r[IDX_W-1:0];
    assign alu_idx_s    = bus.alu_rob_number[IDX_W-1:0];
    // Tags at or above DEPTH (e.g. the RS ready sentinel) never address an entry.
    assign alu_tag_ok_s = ((bus.alu_rob_number >> IDX_W) == {TAG_W{1'b0}});

    // Retire decision on the head entry as registered, plus accept gating for alloc/result.
    always_comb begin
        retire_s   = valid_r[head_idx_s] & ready_r[head_idx_s];
        flush_s    = retire_s & is_branch_r[head_idx_s] & mispredict_r[head_idx_s];
        if (retire_s && !is_branch_r[head_idx_s] && (rd_r[head_idx_s] != 5'd0)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
        alloc_ok_s = bus.alloc_en & (count_r != CNT_FULL) & ~clear_r & ~flush_s;
        alu_ok_s   = bus.alu_en & alu_tag_ok_s & valid_r[alu_idx_s] & ~clear_r;
    end

    // Entry storage, pointers, occupancy and the registered commit/flush outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i]      <= 1'b0;
                ready_r[i]      <= 1'b0;
                is_branch_r[i]  <= 1'b0;
                mispredict_r[i] <= 1'b0;
                rd_r[i]         <= 5'd0;
                val_r[i]        <= 32'd0;
            end
            head_r          <= {TAG_W{1'b0}};
            tail_r          <= {TAG_W{1'b0}};
            count_r         <= {CNT_W{1'b0}};
            commit_en_r     <= 1'b0;
            commit_number_r <= {TAG_W{1'b0}};
            commit_val_r    <= 32'd0;
            commit_rd_r     <= 5'd0;
            clear_r         <= 1'b0;
            redirect_pc_r   <= 32'd0;
        end else if (rdy_in) begin
            if (alloc_ok_s) begin
                valid_r[tail_idx_s]      <= 1'b1;
                ready_r[tail_idx_s]      <= 1'b0;
                mispredict_r[tail_idx_s] <= 1'b0;
                is_branch_r[tail_idx_s]  <= bus.alloc_is_branch;
                rd_r[tail_idx_s]         <= bus.alloc_rd;
                tail_r                   <= ptr_inc(tail_r);
            end
            if (alu_ok_s) begin
                ready_r[alu_idx_s]      <= 1'b1;
                val_r[alu_idx_s]        <= bus.alu_val;
                mispredict_r[alu_idx_s] <= bus.alu_mispredict;
            end
            if (retire_s) begin
                valid_r[head_idx_s] <= 1'b0;
                head_r              <= ptr_inc(head_r);
            end
            count_r     <= count_r + CNT_W'(alloc_ok_s) - CNT_W'(retire_s);
            commit_en_r <= commit_s;
            if (commit_s) begin
                commit_number_r <= head_r;
                commit_val_r    <= val_r[head_idx_s];
                commit_rd_r     <= rd_r[head_idx_s];
            end
            clear_r <= flush_s;
            // A flush wins over the pointer/occupancy updates above.
            if (flush_s) begin
                redirect_pc_r <= val_r[head_idx_s];
                for (int i = 0; i < DEPTH; i++) begin
                    valid_r[i] <= 1'b0;
                end
                head_r  <= {TAG_W{1'b0}};
                tail_r  <= {TAG_W{1'b0}};
                count_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign bus.ROB_Number    = tail_r;
    assign bus.ROB_is_full   = (count_r >= CNT_HIGH);
    assign bus.commit_en     = commit_en_r;
    assign bus.commit_Number = commit_number_r;
    assign bus.commit_val    = commit_val_r;
    assign bus.commit_rd     = commit_rd_r;
    assign bus.clear         = clear_r;
    assign bus.redirect_pc   = redirect_pc_r;
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: in-order commit, full margin, tag wrap, branch flush,
// rdy_in freeze and mid-run reset, each compared against hand-computed values.
module tb_rob;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   order [8] = '{5, 6, 7, 0, 1, 2, 3, 4};

    rob_if #(.TAG_W(5)) bus ();

    rob #(.DEPTH(16), .TAG_W(5)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alloc_en = 1'b0; bus.alloc_rd = 5'd0; bus.alloc_is_branch = 1'b0;
        bus.alu_en = 1'b0; bus.alu_rob_number = 5'd0; bus.alu_val = 32'd0;
        bus.alu_mispredict = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic br);
        bus.alloc_en = 1'b1; bus.alloc_rd = rd; bus.alloc_is_branch = br;
    endtask

    task automatic result(input int tag, input logic [31:0] v, input logic mp);
        bus.alu_en = 1'b1; bus.alu_rob_number = 5'(tag); bus.alu_val = v;
        bus.alu_mispredict = mp;
    endtask

    task automatic chk_commit(input string tag, input int num, input logic [31:0] v,
                              input int rd);
        chk({tag, "_en"}, 32'(bus.commit_en), 32'd1);
        chk({tag, "_num"}, 32'(bus.commit_Number), 32'(num));
        chk({tag, "_val"}, bus.commit_val, v);
        chk({tag, "_rd"}, 32'(bus.commit_rd), 32'(rd));
    endtask

    initial begin
        idle();
        // Reset
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        chk("rst_tag", 32'(bus.ROB_Number), 32'd0);
        chk("rst_full", 32'(bus.ROB_is_full), 32'd0);
        chk("rst_commit", 32'(bus.commit_en), 32'd0);
        chk("rst_clear", 32'(bus.clear), 32'd0);
        chk("rst_cval", bus.commit_val, 32'd0);
        chk("rst_redir", bus.redirect_pc, 32'd0);

        // Out-of-order results, in-order commits
        for (int k = 0; k < 3; k++) begin
            chk("alloc_tag", 32'(bus.ROB_Number), 32'(k));
            alloc(5'(k + 1), 1'b0); tick();
        end
        idle();
        result(2, 32'h11, 1'b0); tick();
        result(0, 32'h22, 1'b0); tick();
        chk("no_bypass", 32'(bus.commit_en), 32'd0);
        result(1, 32'h33, 1'b0); tick();
        chk_commit("c0", 0, 32'h22, 1);
        idle(); tick();
        chk_commit("c1", 1, 32'h33, 2);
        tick();
        chk_commit("c2", 2, 32'h11, 3);
        tick();
        chk("c_end", 32'(bus.commit_en), 32'd0);
        chk("c_tag", 32'(bus.ROB_Number), 32'd3);

        // Fill: full flag at DEPTH-2, alloc ignored at DEPTH
        for (int k = 0; k < 16; k++) begin
            alloc(5'd5, 1'b0); tick();
            if (k == 12) chk("full_13", 32'(bus.ROB_is_full), 32'd0);
            if (k == 13) chk("full_14", 32'(bus.ROB_is_full), 32'd1);
        end
        chk("full_16_tag", 32'(bus.ROB_Number), 32'd3);
        alloc(5'd9, 1'b0); tick(); idle();
        chk("full_drop_tag", 32'(bus.ROB_Number), 32'd3);
        chk("full_count", 32'(dut.count_r), 32'd16);
        for (int i = 0; i < 16; i++) begin
            result((3 + i) % 16, 32'(i), 1'b0); tick();
            if (i >= 1) chk_commit("drain", (3 + i - 1) % 16, 32'(i - 1), 5);
        end
        idle(); tick();
        chk_commit("drain_last", 2, 32'd15, 5);
        tick();

        // Streaming 40 entries through, tags wrap 15->0
        for (int c = 0; c < 40; c++) begin
            alloc(5'd7, 1'b0);
            if (c >= 1) result((3 + c - 1) % 16, 32'h100 + 32'(c - 1), 1'b0);
            tick();
            if (c >= 2) chk_commit("wrap", (3 + c - 2) % 16, 32'h100 + 32'(c - 2), 7);
        end
        idle(); result((3 + 39) % 16, 32'h100 + 32'd39, 1'b0); tick();
        chk_commit("wrap_t38", (3 + 38) % 16, 32'h100 + 32'd38, 7);
        idle(); tick();
        chk_commit("wrap_t39", (3 + 39) % 16, 32'h100 + 32'd39, 7);

        // Mispredicted branch at tag 4 with younger ready entries
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) alloc(5'd0, 1'b1);
            else alloc(5'(k + 1), 1'b0);
            tick();
        end
        idle();
        for (int j = 0; j < 8; j++) begin
            if (order[j] == 4) result(4, 32'h1000, 1'b1);
            else result(order[j], 32'hA0 + 32'(order[j]), 1'b0);
            tick();
            if (j == 3) chk("br_wait", 32'(bus.commit_en), 32'd0);
            if (j >= 4) chk_commit("br_old", j - 4, 32'hA0 + 32'(j - 4), j - 3);
        end
        idle(); alloc(5'd9, 1'b0); tick();
        chk("flush_clear", 32'(bus.clear), 32'd1);
        chk("flush_pc", bus.redirect_pc, 32'h1000);
        chk("flush_commit", 32'(bus.commit_en), 32'd0);
        chk("flush_tag", 32'(bus.ROB_Number), 32'd0);
        chk("flush_count", 32'(dut.count_r), 32'd0);
        alloc(5'd9, 1'b0); result(0, 32'hBEEF, 1'b0); tick();
        chk("post_clear", 32'(bus.clear), 32'd0);
        chk("post_tag", 32'(bus.ROB_Number), 32'd0);
        chk("post_commit", 32'(bus.commit_en), 32'd0);
        idle(); tick();
        chk("post_commit2", 32'(bus.commit_en), 32'd0);

        // rdy_in freeze
        alloc(5'd2, 1'b0); tick();
        alloc(5'd3, 1'b0); tick();
        idle();
        rdy_in = 1'b0; alloc(5'd4, 1'b0); result(0, 32'h55, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("frz_commit", 32'(bus.commit_en), 32'd0);
            chk("frz_tag", 32'(bus.ROB_Number), 32'd2);
        end
        rdy_in = 1'b1; idle(); tick();
        chk("thaw_idle", 32'(bus.commit_en), 32'd0);
        chk("thaw_tag", 32'(bus.ROB_Number), 32'd2);
        result(0, 32'h55, 1'b0); tick();
        chk("thaw_lat", 32'(bus.commit_en), 32'd0);
        result(1, 32'h66, 1'b0); tick();
        chk_commit("thaw_c0", 0, 32'h55, 2);
        rdy_in = 1'b0; tick();
        chk_commit("frz_pulse", 0, 32'h55, 2);
        rdy_in = 1'b1; idle(); tick();
        chk_commit("thaw_c1", 1, 32'h66, 3);
        tick();
        chk("thaw_end", 32'(bus.commit_en), 32'd0);

        // Reset with 5 pending entries
        for (int k = 0; k < 5; k++) begin
            alloc(5'(k + 1), 1'b0); tick();
        end
        idle(); result(2, 32'h77, 1'b0); tick();
        rst_in = 1'b1; result(3, 32'h88, 1'b0); tick();
        rst_in = 1'b0; idle();
        chk("mrst_commit", 32'(bus.commit_en), 32'd0);
        chk("mrst_count", 32'(dut.count_r), 32'd0);
        chk("mrst_tag", 32'(bus.ROB_Number), 32'd0);
        chk("mrst_full", 32'(bus.ROB_is_full), 32'd0);
        chk("mrst_clear", 32'(bus.clear), 32'd0);
        chk("mrst_num", 32'(bus.commit_Number), 32'd0);
        chk("mrst_val", bus.commit_val, 32'd0);
        chk("mrst_rd", 32'(bus.commit_rd), 32'd0);
        chk("mrst_redir", bus.redirect_pc, 32'd0);
        tick();
        chk("mrst_after", 32'(bus.commit_en), 32'd0);
        tick();
        chk("mrst_after2", 32'(bus.commit_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
